// File: rtl/m_sorted_serializer_if.sv
// Valid/ready element stream from the sorted serializer to its consumer.
// Carries data, index and last marker alongside the handshake pair.
interface m_sorted_serializer_if #(
  parameter int WIDTH = 3,
  parameter int IDXW  = 7
);
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/m_sorted_serializer.sv
// Captures the sorted 2n-element bus on start and streams it out lowest first.
// Define SER_ORDER_CHECK_EN to add the sticky out-of-order detector.
module m_sorted_serializer #(
  parameter int WIDTH = 3,
  parameter int n     = 64,
  parameter int IDXW  = $clog2(2*n)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*n*WIDTH-1:0]  c,
  output logic                  busy,
  output logic                  done,
  output logic                  order_err,
  m_sorted_serializer_if.master out
);

  localparam logic [IDXW-1:0] LAST = IDXW'(2*n-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [2*n*WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0]     cur;
  logic                 accept;
  logic                 cap;

  assign cur    = shadow_q[int'(idx_q)*WIDTH +: WIDTH];
  assign accept = (state_q == S_STREAM) && out.out_ready;
  assign cap    = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = c;
          idx_d    = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (idx_q == LAST) state_d = S_DONE;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops valid immediately
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign out.out_valid = (state_q == S_STREAM);
  assign out.out_data  = out.out_valid ? cur : '0;
  assign out.out_idx   = idx_q;
  assign out.out_last  = out.out_valid && (idx_q == LAST);

`ifdef SER_ORDER_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             err_q, err_d;

  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (cap) begin
      err_d = 1'b0;
    end else if (accept) begin
      prev_d = cur;
      if (idx_q != '0 && cur < prev_q) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_m_sorted_serializer.sv
// Directed bench for m_sorted_serializer: n=4 unit plus an n=64 instance.
// Inputs change and outputs are sampled on the falling edge.
module tb_m_sorted_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] c;
  logic        busy, done, order_err;

  logic         start64;
  logic [383:0] c64;
  logic         busy64, done64, order_err64;

  int vecs = 0;
  int errs = 0;
  logic [2:0] vals [8];

  m_sorted_serializer_if #(.WIDTH(3), .IDXW(3)) sif ();
  m_sorted_serializer_if #(.WIDTH(3), .IDXW(7)) sif64 ();

  m_sorted_serializer #(.WIDTH(3), .n(4)) dut (
    .clk(clk), .rst(rst), .start(start), .c(c),
    .busy(busy), .done(done), .order_err(order_err),
    .out(sif.master)
  );

  m_sorted_serializer #(.WIDTH(3), .n(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .c(c64),
    .busy(busy64), .done(done64), .order_err(order_err64),
    .out(sif64.master)
  );

  always #5 clk = ~clk;

  task automatic load_c();
    for (int i = 0; i < 8; i++) c[i*3 +: 3] = vals[i];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    sif.out_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL drain_timeout done=%0b required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; c = '0; sif.out_ready = 1'b0;
    start64 = 1'b0; c64 = '0; sif64.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({busy, done, order_err, sif.out_valid, sif.out_last} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags got %b required 00000",
               {busy, done, order_err, sif.out_valid, sif.out_last});
    end
    vecs++;
    if ({sif.out_data, sif.out_idx} !== 6'b0) begin
      errs++;
      $display("FAIL reset_data got %0d/%0d required 0/0",
               sif.out_data, sif.out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_idle busy=%0b valid=%0b required 0/0",
               busy, sif.out_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) vals[i] = 3'(i);
    load_c();
    sif.out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (sif.out_valid !== 1'b1 || sif.out_data !== 3'(k) ||
          sif.out_idx !== 3'(k) || sif.out_last !== (k == 7)) begin
        errs++;
        $display("FAIL stream_k%0d got v=%0b d=%0d i=%0d l=%0b required 1/%0d/%0d/%0b",
                 k, sif.out_valid, sif.out_data, sif.out_idx,
                 sif.out_last, k, k, (k == 7));
      end
      @(negedge clk);
    end
    vecs++;
    if (done !== 1'b1 || sif.out_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL stream_done got d=%0b v=%0b b=%0b required 1/0/1",
               done, sif.out_valid, busy);
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || sif.out_idx !== 3'd0) begin
      errs++;
      $display("FAIL stream_idle got d=%0b b=%0b i=%0d required 0/0/0",
               done, busy, sif.out_idx);
    end
  endtask

  task automatic test_backpressure();
    int  exp_idx;
    bit  got_done;
    vals = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7};
    load_c();
    exp_idx  = 0;
    got_done = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
      if (sif.out_valid) begin
        vecs++;
        if (sif.out_idx !== 3'(exp_idx) || sif.out_data !== vals[exp_idx]) begin
          errs++;
          $display("FAIL bp_cyc%0d got i=%0d d=%0d required %0d/%0d",
                   cyc, sif.out_idx, sif.out_data, exp_idx, vals[exp_idx]);
        end
      end
      if (done) got_done = 1'b1;
      sif.out_ready = (cyc % 3 == 0);
      if (sif.out_valid && sif.out_ready && exp_idx < 7) exp_idx++;
      else if (sif.out_valid && sif.out_ready) exp_idx = 8;
      @(negedge clk);
    end
    vecs++;
    if (!got_done || exp_idx != 8) begin
      errs++;
      $display("FAIL bp_count got done=%0b accepted=%0d required 1/8",
               got_done, exp_idx);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    for (int i = 0; i < 8; i++) vals[i] = 3'(i);
    load_c();
    sif.out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (sif.out_data !== 3'(k) || busy !== 1'b1) begin
        errs++;
        $display("FAIL ign_k%0d got d=%0d b=%0b required %0d/1",
                 k, sif.out_data, busy, k);
      end
      if (k == 0) c = '1;
      start = (k == 2);
      @(negedge clk);
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL ign_done got %0b required 1", done);
    end
    start = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL done_cycle_start got busy=%0b required 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || sif.out_idx !== 3'd0 || sif.out_data !== 3'd7) begin
      errs++;
      $display("FAIL restart_idle got b=%0b i=%0d d=%0d required 1/0/7",
               busy, sif.out_idx, sif.out_data);
    end
    drain();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) vals[i] = 3'(7 - i);
    vals[0] = 3'd2;
    for (int i = 1; i < 8; i++) vals[i] = 3'(i);
    load_c();
    sif.out_ready = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    vecs++;
    if (sif.out_idx !== 3'd3) begin
      errs++;
      $display("FAIL abort_pre got idx=%0d required 3", sif.out_idx);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_async got v=%0b b=%0b required 0/0",
               sif.out_valid, busy);
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b0 || sif.out_idx !== 3'd0) begin
      errs++;
      $display("FAIL abort_nodone got d=%0b i=%0d required 0/0",
               done, sif.out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    vecs++;
    if (sif.out_valid !== 1'b1 || sif.out_idx !== 3'd0 ||
        sif.out_data !== 3'd2) begin
      errs++;
      $display("FAIL abort_restart got v=%0b i=%0d d=%0d required 1/0/2",
               sif.out_valid, sif.out_idx, sif.out_data);
    end
    drain();
  endtask

  task automatic test_order();
    bit exp_on;
`ifdef SER_ORDER_CHECK_EN
    exp_on = 1'b1;
`else
    exp_on = 1'b0;
`endif
    vals = '{3'd0, 3'd1, 3'd5, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    load_c();
    sif.out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (order_err !== (exp_on && k >= 4)) begin
        errs++;
        $display("FAIL order_k%0d got %0b required %0b",
                 k, order_err, (exp_on && k >= 4));
      end
      @(negedge clk);
    end
    @(negedge clk);
    vecs++;
    if (order_err !== exp_on) begin
      errs++;
      $display("FAIL order_sticky got %0b required %0b", order_err, exp_on);
    end
    for (int i = 0; i < 8; i++) vals[i] = 3'(i);
    load_c();
    pulse_start();
    vecs++;
    if (order_err !== 1'b0) begin
      errs++;
      $display("FAIL order_clear got %0b required 0", order_err);
    end
    drain();
  endtask

  task automatic test_large();
    logic [2:0] refv [128];
    int cnt [8];
    int pos, seen, done_cyc;
    for (int v = 0; v < 8; v++) cnt[v] = 0;
    for (int i = 0; i < 128; i++) cnt[$urandom_range(7)]++;
    pos = 0;
    for (int v = 0; v < 8; v++)
      for (int j = 0; j < cnt[v]; j++) begin
        refv[pos] = 3'(v);
        pos++;
      end
    for (int i = 0; i < 128; i++) c64[i*3 +: 3] = refv[i];
    sif64.out_ready = 1'b1;
    seen     = 0;
    done_cyc = -1;
    start64  = 1'b1;
    @(negedge clk);
    start64  = 1'b0;
    for (int cyc = 1; cyc < 140 && done_cyc < 0; cyc++) begin
      if (sif64.out_valid) begin
        vecs++;
        if (sif64.out_idx !== 7'(seen) || sif64.out_data !== refv[seen]) begin
          errs++;
          $display("FAIL large_e%0d got i=%0d d=%0d required %0d/%0d",
                   seen, sif64.out_idx, sif64.out_data, seen, refv[seen]);
        end
        if (seen < 127) seen++;
        else seen = 128;
      end
      if (done64) done_cyc = cyc;
      @(negedge clk);
    end
    vecs++;
    if (done_cyc != 129 || seen != 128) begin
      errs++;
      $display("FAIL large_done got cyc=%0d n=%0d required 129/128",
               done_cyc, seen);
    end
    vecs++;
    if (busy64 !== 1'b0 || order_err64 !== 1'b0) begin
      errs++;
      $display("FAIL large_idle got b=%0b e=%0b required 0/0",
               busy64, order_err64);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ignore_start();
    test_abort();
    test_order();
    test_large();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
